// File: rtl/toy_pkg.sv
// toy_pkg: shared opcode constants, pipeline register layouts and load-capture FSM states
package toy_pkg;
  localparam int unsigned ADDI = 0;
  localparam int unsigned ADD  = 1;
  localparam int unsigned SUB  = 2;
  localparam int unsigned AND  = 3;
  localparam int unsigned OR   = 4;
  localparam int unsigned XOR  = 5;
  localparam int unsigned SLL  = 6;
  localparam int unsigned SRL  = 7;
  localparam int unsigned SRA  = 8;
  localparam int unsigned SLT  = 9;
  localparam int unsigned ANDI = 10;
  localparam int unsigned ORI  = 11;
  localparam int unsigned XORI = 12;
  localparam int unsigned SLTI = 13;
  localparam int unsigned LUI  = 14;
  localparam int unsigned BEQ  = 15;
  localparam int unsigned BNE  = 16;
  localparam int unsigned J    = 17;
  localparam int unsigned JR   = 18;
  localparam int unsigned LD   = 19;
  localparam int unsigned LDR  = 20;
  localparam int unsigned ST   = 21;
  localparam int unsigned STR  = 22;

  typedef enum logic {LIVE = 1'b0, HELD = 1'b1} hold_state_e;

  typedef struct packed {
    logic        valid;
    logic [4:0]  dest;
    logic        we;
    logic [31:0] aluout;
    logic [31:0] stdata;
  } xm_t;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [4:0]  dest;
    logic [31:0] aluout;
    logic        is_load;
  } mw_t;

  function automatic logic op_is_load(input int unsigned op);
    return op == LD || op == LDR;
  endfunction

  function automatic logic op_is_store(input int unsigned op);
    return op == ST || op == STR;
  endfunction
endpackage

// File: rtl/toy_mem_stage_if.sv
// toy_mem_stage_if: synchronous data-memory port (DRDATA valid the cycle after a read request)
interface toy_mem_stage_if;
  logic        DREQ;
  logic        DRW;
  logic [29:0] DADDR;
  logic [31:0] DWDATA;
  logic [31:0] DRDATA;
  modport master (output DREQ, DRW, DADDR, DWDATA, input DRDATA);
  modport slave  (input DREQ, DRW, DADDR, DWDATA, output DRDATA);
endinterface

// File: rtl/toy_ld_hold.sv
// toy_ld_hold: keeps load data alive across a stall by latching DRDATA into a hold buffer
module toy_ld_hold
  import toy_pkg::*;
(
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        stall_i,
  input  logic        mw_load_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);
  hold_state_e state_q, state_d;
  logic [31:0] hold_q, hold_d;
  // Enter HELD on the first stalled cycle of a load, grabbing the data the memory presents that cycle
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (state_q == LIVE && stall_i && mw_load_i) begin
      state_d = HELD;
      hold_d  = rdata_i;
    end else if (state_q == HELD && !stall_i) begin
      state_d = LIVE;
    end
  end
  // State and hold buffer registers; reset drops any pending load data
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= LIVE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end
  assign ld_data_o = state_q == HELD ? hold_q : rdata_i;
endmodule

// File: rtl/toy_mem_stage.sv
// toy_mem_stage: MEM pipeline stage (XM/MW registers, data-memory access, write-back); TOY_MEM_FWD_EN enables the XM forwarding tap
module toy_mem_stage
  import toy_pkg::*;
#(
  parameter int OP_W = 5
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            ex_valid,
  input  logic [OP_W-1:0] ex_op,
  input  logic [4:0]      ex_dest,
  input  logic            ex_we,
  input  logic [31:0]     ex_aluout,
  input  logic [31:0]     ex_stdata,
  input  logic            flush,
  input  logic            stall,
  toy_mem_stage_if.master dmem,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [4:0]      wb_dest,
  output logic [31:0]     wb_data,
  output logic            fwd_valid,
  output logic [4:0]      fwd_dest,
  output logic [31:0]     fwd_data,
  output logic            xm_is_load
);
  xm_t xm_q, xm_d;
  mw_t mw_q, mw_d;
  logic [OP_W-1:0] xm_op_q, xm_op_d;
  logic xm_ld, xm_st;
  logic [31:0] ld_data;

  assign xm_ld = op_is_load(32'(xm_op_q));
  assign xm_st = op_is_store(32'(xm_op_q));

  // Advance both registers when not stalled; flush kills the XM entry even under stall
  always_comb begin
    xm_d    = xm_q;
    xm_op_d = xm_op_q;
    mw_d    = mw_q;
    if (!stall) begin
      xm_d    = '{valid: ex_valid, dest: ex_dest, we: ex_we, aluout: ex_aluout, stdata: ex_stdata};
      xm_op_d = ex_op;
      mw_d    = '{valid: xm_q.valid, we: xm_q.we & ~xm_st, dest: xm_q.dest, aluout: xm_q.aluout,
                  is_load: xm_ld};
    end
    if (flush) xm_d.valid = 1'b0;
  end

  // Pipeline registers
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      xm_q    <= '0;
      xm_op_q <= '0;
      mw_q    <= '0;
    end else begin
      xm_q    <= xm_d;
      xm_op_q <= xm_op_d;
      mw_q    <= mw_d;
    end
  end

  toy_ld_hold u_hold (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .stall_i   (stall),
    .mw_load_i (mw_q.valid & mw_q.is_load),
    .rdata_i   (dmem.DRDATA),
    .ld_data_o (ld_data)
  );

  assign dmem.DREQ   = xm_q.valid & (xm_ld | xm_st) & ~stall;
  assign dmem.DRW    = ~(xm_q.valid & xm_st);
  assign dmem.DADDR  = xm_q.aluout[29:0];
  assign dmem.DWDATA = xm_q.stdata;
  assign wb_valid    = mw_q.valid;
  assign wb_we       = mw_q.valid & mw_q.we;
  assign wb_dest     = mw_q.dest;
  assign wb_data     = mw_q.is_load ? ld_data : mw_q.aluout;
  assign xm_is_load  = xm_q.valid & xm_ld;
`ifdef TOY_MEM_FWD_EN
  assign fwd_valid = xm_q.valid & xm_q.we & ~xm_ld;
  assign fwd_dest  = xm_q.dest;
  assign fwd_data  = xm_q.aluout;
`else
  assign fwd_valid = 1'b0;
  assign fwd_dest  = '0;
  assign fwd_data  = '0;
`endif
endmodule
